comparator_nbit_serial: RTL and testbench

- Parametrised, bit-serial N-bit magnitude comparator; the multi-cycle successor to the 1-bit comparator.
- Compares two WIDTH-bit operands MSB-first, one bit per clock, under a start/done handshake.
- Supports unsigned or two's-complement operands and optional early termination on the first differing bit.
- Sits between datapath registers and control logic where area is favoured over single-cycle latency.

---
 rtl/comparator_nbit_serial.sv | 152 +++++++++++++++
 tb/tb_comparator_nbit_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_nbit_serial.sv
//------------------------------------------------------------------------------
// comparator_nbit_serial
//
// Bit-serial WIDTH-bit magnitude comparator. The operands are captured when
// start is accepted and are then scanned MSB-first, one bit per clock. The
// comparison ends on the first differing bit (EARLY_EXIT=1) or after all
// WIDTH bits (EARLY_EXIT=0, fixed latency). Operands may be unsigned or
// two's complement (SIGNED).
//
// Parameters
//   WIDTH      : operand width in bits, 1..32
//   SIGNED     : 0 = unsigned operands, 1 = two's-complement operands
//   EARLY_EXIT : 1 = finish on the first differing bit, 0 = scan all bits
//
// Ports
//   clk   : in  1      rising-edge clock
//   rst   : in  1      synchronous active-high reset
//   start : in  1      request a comparison, sampled only when idle
//   a     : in  WIDTH  operand A, captured on the accepted start edge
//   b     : in  WIDTH  operand B, captured on the accepted start edge
//   busy  : out 1      high while a comparison is in progress
//   done  : out 1      one-cycle pulse when y has been updated
//   y     : out 3      {A>B, A==B, A<B}; held until the next decision or reset
//------------------------------------------------------------------------------
module comparator_nbit_serial #(
   parameter int WIDTH      = 8,
   parameter int SIGNED     = 0,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [2:0]       y
);

   localparam int                IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0]  MSB_IDX  = IDX_W'(WIDTH - 1);
   localparam logic              SIGN_INV = (SIGNED != 0);
   localparam logic              EE_ON    = (EARLY_EXIT != 0);

   localparam logic [2:0] Y_GT = 3'b100;
   localparam logic [2:0] Y_EQ = 3'b010;
   localparam logic [2:0] Y_LT = 3'b001;

   typedef enum logic {
      S_IDLE,
      S_COMPARE
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [IDX_W-1:0]  r_idx;
   logic              r_found;    // first difference already recorded
   logic [2:0]        r_outcome;  // outcome of the first difference
   logic              r_busy;
   logic              r_done;
   logic [2:0]        r_y;

   logic [WIDTH-1:0]  w_a_shift;
   logic [WIDTH-1:0]  w_b_shift;
   logic              w_a_bit;
   logic              w_b_bit;
   logic              w_diff;
   logic              w_at_msb;
   logic              w_at_lsb;
   logic              w_a_greater;
   logic [2:0]        w_bit_outcome;
   logic              w_decide;
   logic [2:0]        w_final;

   // Shifting the current bit down to position 0 keeps the bit select legal
   // for every WIDTH, including WIDTH=1 where an index would be zero-width.
   assign w_a_shift = r_a >> r_idx;
   assign w_b_shift = r_b >> r_idx;
   assign w_a_bit   = w_a_shift[0];
   assign w_b_bit   = w_b_shift[0];
   assign w_diff    = w_a_bit ^ w_b_bit;

   assign w_at_msb  = (r_idx == MSB_IDX);
   assign w_at_lsb  = (r_idx == '0);

   // In two's complement a 1 in the sign position marks the smaller value,
   // so the sense of a sign-bit difference is inverted.
   assign w_a_greater   = w_a_bit ^ (SIGN_INV & w_at_msb);
   assign w_bit_outcome = w_a_greater ? Y_GT : Y_LT;

   // The LSB always ends the scan; any difference ends it early if enabled.
   assign w_decide = (EE_ON & w_diff) | w_at_lsb;

   // Once a difference has been recorded, later bits cannot change the result.
   assign w_final = r_found ? r_outcome :
                    (w_diff ? w_bit_outcome : Y_EQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_found   <= 1'b0;
         r_outcome <= 3'b000;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_y       <= 3'b000;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_idx     <= MSB_IDX;
                  r_found   <= 1'b0;
                  r_outcome <= 3'b000;
                  r_busy    <= 1'b1;
                  r_state   <= S_COMPARE;
               end
            end

            S_COMPARE: begin
               if (w_diff && !r_found) begin
                  r_found   <= 1'b1;
                  r_outcome <= w_bit_outcome;
               end
               if (w_decide) begin
                  r_y     <= w_final;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign y    = r_y;

endmodule

// File: tb/tb_comparator_nbit_serial.sv
//------------------------------------------------------------------------------
// tb_comparator_nbit_serial
//
// Directed bench for comparator_nbit_serial. Five instances cover the
// configurations of interest:
//   0 : WIDTH=8 unsigned, early exit
//   1 : WIDTH=8 signed,   early exit
//   2 : WIDTH=8 unsigned, full scan
//   3 : WIDTH=1 unsigned
//   4 : WIDTH=1 signed
// Instances 0..2 share one stimulus set, instances 3..4 another. Expected
// latencies (edges after the start edge) and results are hand-computed.
//------------------------------------------------------------------------------
module tb_comparator_nbit_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;

   logic       busy_v [5];
   logic       done_v [5];
   logic [2:0] y_v    [5];

   int checks = 0;
   int errors = 0;

   int exp_lat [5];
   int exp_y   [5];

   always #5 clk = ~clk;

   comparator_nbit_serial #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) u_u8e (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]));

   comparator_nbit_serial #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(1)) u_s8e (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]));

   comparator_nbit_serial #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(0)) u_u8f (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]));

   comparator_nbit_serial #(.WIDTH(1), .SIGNED(0), .EARLY_EXIT(1)) u_u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy_v[3]), .done(done_v[3]), .y(y_v[3]));

   comparator_nbit_serial #(.WIDTH(1), .SIGNED(1), .EARLY_EXIT(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy_v[4]), .done(done_v[4]), .y(y_v[4]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; sample and drive 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp8(input int l0, input int y0, input int l1, input int y1,
                           input int l2, input int y2);
      exp_lat[0] = l0; exp_y[0] = y0;
      exp_lat[1] = l1; exp_y[1] = y1;
      exp_lat[2] = l2; exp_y[2] = y2;
   endtask

   // One comparison on a group of instances. Checks latency, result, the
   // number of done pulses, busy duration and that busy/done never overlap.
   // With disturb set, a is changed to FF and start pulsed after edge E1.
   task automatic run(input string name, input bit one_bit, input logic [7:0] av,
                      input logic [7:0] bv, input bit disturb);
      int lo, hi;
      int ndone [5];
      int nbusy [5];
      int lat   [5];
      int yv    [5];
      int overlap;
      lo = one_bit ? 3 : 0;
      hi = one_bit ? 4 : 2;
      overlap = 0;
      if (one_bit) begin
         a1 = av[0:0]; b1 = bv[0:0]; start1 = 1'b1;
      end else begin
         a8 = av; b8 = bv; start8 = 1'b1;
      end
      tick();
      start1 = 1'b0;
      start8 = 1'b0;
      for (int i = lo; i <= hi; i++) begin
         ndone[i] = 0; lat[i] = 0; yv[i] = 0;
         nbusy[i] = busy_v[i] ? 1 : 0;
      end
      for (int c = 1; c <= 12; c++) begin
         tick();
         for (int i = lo; i <= hi; i++) begin
            if (done_v[i]) begin
               ndone[i]++;
               lat[i] = c;
               yv[i]  = int'(y_v[i]);
            end
            if (busy_v[i]) nbusy[i]++;
            if (busy_v[i] && done_v[i]) overlap++;
         end
         if (disturb && c == 1) begin
            a8 = 8'hFF; start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
      end
      for (int i = lo; i <= hi; i++) begin
         check($sformatf("%s.u%0d.lat",   name, i), lat[i],   exp_lat[i]);
         check($sformatf("%s.u%0d.y",     name, i), yv[i],    exp_y[i]);
         check($sformatf("%s.u%0d.ndone", name, i), ndone[i], 1);
         check($sformatf("%s.u%0d.busy",  name, i), nbusy[i], exp_lat[i]);
         $display("TXN %s u%0d a=%h b=%h lat=%0d y=%03b dones=%0d", name, i,
                  av, bv, lat[i], yv[i][2:0], ndone[i]);
      end
      check($sformatf("%s.overlap", name), overlap, 0);
   endtask

   initial begin
      int c;
      int nd;
      rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; a1 = '0; b1 = '0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset.u%0d.busy", i), busy_v[i], 0);
         check($sformatf("reset.u%0d.done", i), done_v[i], 0);
         check($sformatf("reset.u%0d.y",    i), y_v[i],    0);
      end
      $display("TXN reset");

      // Equal operands: every configuration scans all 8 bits.
      set_exp8(8, 3'b010, 8, 3'b010, 8, 3'b010);
      run("eq5a", 0, 8'h5A, 8'h5A, 0);

      // MSB difference: signed sense inverted (-128 < 127).
      set_exp8(1, 3'b100, 1, 3'b001, 8, 3'b100);
      run("msb", 0, 8'h80, 8'h7F, 0);

      // LSB difference: all take 8 cycles.
      set_exp8(8, 3'b100, 8, 3'b100, 8, 3'b100);
      run("lsb", 0, 8'h03, 8'h02, 0);

      // Sign-bit difference, fixed latency still 8 in full-scan mode.
      set_exp8(1, 3'b100, 1, 3'b001, 8, 3'b100);
      run("sign", 0, 8'h80, 8'h00, 0);

      // First difference at bit 6; later opposing differences are ignored.
      set_exp8(2, 3'b100, 2, 3'b100, 8, 3'b100);
      run("later", 0, 8'h40, 8'h3F, 0);

      // Negative operands: -2 < -1, decided at bit 0.
      set_exp8(8, 3'b001, 8, 3'b001, 8, 3'b001);
      run("neg", 0, 8'hFE, 8'hFF, 0);

      // Operand change and start while busy have no effect.
      set_exp8(3, 3'b001, 3, 3'b001, 8, 3'b001);
      run("iso", 0, 8'h10, 8'h20, 1);

      // Reset during cycle 4 of an equal-operand compare.
      a8 = 8'h5A; b8 = 8'h5A; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("abort.u%0d.busy", i), busy_v[i], 0);
         check($sformatf("abort.u%0d.done", i), done_v[i], 0);
         check($sformatf("abort.u%0d.y",    i), y_v[i],    0);
      end
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         for (int i = 0; i < 3; i++) if (done_v[i]) nd++;
      end
      check("abort.stale_done", nd, 0);
      $display("TXN abort stale_dones=%0d", nd);

      // Reset and start together: reset wins.
      rst = 1'b1; start8 = 1'b1;
      tick();
      rst = 1'b0; start8 = 1'b0;
      for (int i = 0; i < 3; i++)
         check($sformatf("rst_start.u%0d.busy", i), busy_v[i], 0);
      $display("TXN rst_with_start");

      // Back-to-back on instance 0: start accepted during the done cycle.
      a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      c = 0;
      while (!done_v[0] && c < 20) begin
         tick();
         c++;
      end
      check("b2b.first.lat", c, 7);
      check("b2b.first.y", y_v[0], 3'b001);
      $display("TXN b2b first lat=%0d y=%03b", c, y_v[0]);
      a8 = 8'h02; b8 = 8'h01; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("b2b.accept.busy", busy_v[0], 1);
      check("b2b.accept.done", done_v[0], 0);
      c = 0;
      while (!done_v[0] && c < 20) begin
         tick();
         c++;
      end
      check("b2b.second.lat", c, 7);
      check("b2b.second.y", y_v[0], 3'b100);
      $display("TXN b2b second lat=%0d y=%03b", c, y_v[0]);
      for (int k = 0; k < 12; k++) tick();

      // WIDTH=1: exhaustive, unsigned (u3) and signed (u4).
      exp_lat[3] = 1; exp_lat[4] = 1;
      exp_y[3] = 3'b010; exp_y[4] = 3'b010; run("w1_00", 1, 8'h00, 8'h00, 0);
      exp_y[3] = 3'b001; exp_y[4] = 3'b100; run("w1_01", 1, 8'h00, 8'h01, 0);
      exp_y[3] = 3'b100; exp_y[4] = 3'b001; run("w1_10", 1, 8'h01, 8'h00, 0);
      exp_y[3] = 3'b010; exp_y[4] = 3'b010; run("w1_11", 1, 8'h01, 8'h01, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
